// File: rtl/fetch_sched_pkg.sv
// fetch_sched_pkg: shared constants, state encoding and burst sizing helper
// for the frame fetch scheduler.
package fetch_sched_pkg;

    localparam int ATTRMAX   = 31;
    localparam int BEATBYTES = 8;

    typedef enum logic [1:0] {FS_IDLE, FS_CALC, FS_ISSUE, FS_DRAIN} fs_state_e;

    function automatic logic [8:0] burst_len(input logic [15:0] rem, input int burst);
        return (rem > 16'(burst)) ? 9'(burst) : rem[8:0];
    endfunction

endpackage

// File: rtl/fetch_credit.sv
// fetch_credit: downstream FIFO credit counter, clamped to FIFODEPTH, with
// simultaneous return/consume and a "credit covers this burst" flag.
module fetch_credit #(
    parameter int FIFODEPTH = 512,
    parameter int CW        = $clog2(FIFODEPTH + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       inc,
    input  logic       dec,
    input  logic [8:0] len,
    output logic       ok
);

    logic [CW-1:0] credit;
    logic [17:0]   sum;
    logic [CW-1:0] credit_nxt;

    // a return at full credit is dropped so the count can never exceed the FIFO
    always_comb begin
        sum        = 18'(credit) + 18'(inc && credit != CW'(FIFODEPTH)) - (dec ? 18'(len) : 18'd0);
        credit_nxt = (sum > 18'(FIFODEPTH)) ? CW'(FIFODEPTH) : CW'(sum);
        ok         = 18'(credit) >= 18'(len);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            credit <= CW'(FIFODEPTH);
        else
            credit <= load ? CW'(FIFODEPTH) : credit_nxt;

endmodule

// File: rtl/fetch_sched.sv
// fetch_sched: walks the active frame and issues credit-gated burst reads,
// re-timing returned beats to dmado/dmavalid. FETCH_STATS_EN enables the abort counter.
module fetch_sched
    import fetch_sched_pkg::*;
#(
    parameter int BURST     = 16,
    parameter int FIFODEPTH = 512,
    parameter int AW        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkdmastart,
    input  logic [ATTRMAX:0] attr,
    input  logic [AW-1:0]    fbaddr,
    input  logic [15:0]      stride,
    output logic             rdreq,
    output logic [AW-1:0]    rdaddr,
    output logic [7:0]       rdlen,
    input  logic             rdack,
    input  logic [47:0]      rddata,
    input  logic             rdvalid,
    input  logic             fiforden,
    output logic [47:0]      dmado,
    output logic             dmavalid,
    output logic             framedone,
    output logic [15:0]      aborts
);

    fs_state_e     state, state_nxt;
    logic [15:0]   hact, vact, pitch;
    logic [AW-1:0] lineaddr;
    logic [15:0]   bcnt, ycnt, outstanding, dropcnt;
    logic          restart;
    logic [15:0]   lbeats, bnext, out_nxt;
    logic [8:0]    len;
    logic          acc, abort, line_end, last, empty, credit_ok;
    logic          launch, reload, done;

    assign acc      = rdreq && rdack;
    assign abort    = clkdmastart && state != FS_IDLE;
    assign lbeats   = 16'(({1'b0, hact} + 17'd1) >> 1);
    assign len      = burst_len(lbeats - bcnt, BURST);
    assign bnext    = bcnt + 16'(len);
    assign line_end = bnext == lbeats;
    assign last     = line_end && (ycnt + 16'd1 == vact);
    assign empty    = hact == '0 || vact == '0;
    assign out_nxt  = outstanding + (acc ? 16'(len) : 16'd0) - 16'(rdvalid);

    fetch_credit #(.FIFODEPTH(FIFODEPTH)) u_credit (
        .clk   (clk),
        .reset (reset),
        .load  (reload),
        .inc   (fiforden),
        .dec   (acc),
        .len   (len),
        .ok    (credit_ok)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= FS_IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  state_nxt = clkdmastart ? FS_CALC : FS_IDLE;
            FS_CALC:  state_nxt = (abort || empty) ? FS_DRAIN : credit_ok ? FS_ISSUE : FS_CALC;
            FS_ISSUE: state_nxt = (abort || (acc && last)) ? FS_DRAIN : acc ? FS_CALC : FS_ISSUE;
            FS_DRAIN: state_nxt = (abort || outstanding != '0) ? FS_DRAIN : restart ? FS_CALC : FS_IDLE;
            default:  state_nxt = FS_IDLE;
        endcase
    end

    // an aborted frame leaves DRAIN straight into CALC for the new frame, without framedone
    always_comb begin
        launch = state == FS_CALC && state_nxt == FS_ISSUE;
        reload = state == FS_DRAIN && state_nxt == FS_CALC;
        done   = state == FS_DRAIN && state_nxt == FS_IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hact        <= '0;
            vact        <= '0;
            pitch       <= '0;
            lineaddr    <= '0;
            bcnt        <= '0;
            ycnt        <= '0;
            outstanding <= '0;
            dropcnt     <= '0;
            restart     <= 1'b0;
            rdreq       <= 1'b0;
            rdaddr      <= '0;
            rdlen       <= '0;
            dmado       <= '0;
            dmavalid    <= 1'b0;
            framedone   <= 1'b0;
        end else begin
            if (clkdmastart) begin
                hact     <= attr[31:16];
                vact     <= attr[15:0];
                pitch    <= stride;
                lineaddr <= fbaddr;
                bcnt     <= '0;
                ycnt     <= '0;
            end else if (acc) begin
                bcnt     <= line_end ? 16'd0 : bnext;
                ycnt     <= ycnt + 16'(line_end);
                lineaddr <= line_end ? lineaddr + AW'(pitch) : lineaddr;
            end
            outstanding <= out_nxt;
            // beats already in flight when the frame is aborted are swallowed here
            dropcnt     <= abort ? out_nxt : (rdvalid && dropcnt != '0) ? dropcnt - 16'd1 : dropcnt;
            restart     <= abort ? 1'b1 : reload ? 1'b0 : restart;
            rdreq       <= state_nxt == FS_ISSUE;
            if (launch) begin
                rdaddr <= lineaddr + AW'(bcnt) * AW'(BEATBYTES);
                rdlen  <= 8'(len - 9'd1);
            end
            dmado     <= rddata;
            dmavalid  <= rdvalid && dropcnt == '0;
            framedone <= done;
        end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset)
            aborts <= '0;
        else if (abort && aborts != 16'hFFFF)
            aborts <= aborts + 16'd1;
`else
    assign aborts = '0;
`endif

endmodule
